// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: per-channel rise/fall/pulse detectors feeding pending
// flags, shared through a round-robin arbiter onto one valid/ready output.
module edge_event_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     in,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [1:0]       cfg_mode,
  input  logic             ovf_clr,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDX_W-1:0] evt_idx,
  output logic [1:0]       evt_kind,
  output logic [N-1:0]     overflow
);

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_RISE  = 2'b01;
  localparam logic [1:0] MODE_FALL  = 2'b10;
  localparam logic [1:0] MODE_PULSE = 2'b11;

  logic [1:0]       mode [N];
  logic [N-1:0]     h0;
  logic [N-1:0]     h1;
  logic [N-1:0]     pending;
  logic [N-1:0]     detect;
  logic [N-1:0]     cfg_hit;
  logic [N-1:0]     grant_sel;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_hit;
  logic             load;

  // Output register is free when empty or being drained this cycle.
  assign load = !evt_valid || evt_ready;

  // Per-channel edge/pulse detection from the current input and its history.
  always_comb begin
    detect = '0;
    for (int i = 0; i < N; i++) begin
      case (mode[i])
        MODE_RISE:  detect[i] = ~h0[i] & in[i];
        MODE_FALL:  detect[i] = h0[i] & ~in[i];
        MODE_PULSE: detect[i] = ~h1[i] & h0[i] & ~in[i];
        MODE_OFF:   detect[i] = 1'b0;
        default:    detect[i] = 1'b0;
      endcase
    end
  end

  // Decode which channel the config port addresses and which one is granted.
  always_comb begin
    cfg_hit   = '0;
    grant_sel = '0;
    for (int i = 0; i < N; i++) begin
      cfg_hit[i]   = cfg_we && (cfg_idx == IDX_W'(i));
      grant_sel[i] = load && grant_hit && (grant_idx == IDX_W'(i));
    end
  end

  // Round-robin search: walk backwards so the nearest channel after ptr wins.
  always_comb begin
    int c;
    c         = 0;
    grant_hit = 1'b0;
    grant_idx = '0;
    for (int k = N; k >= 1; k--) begin
      c = (int'(ptr) + k) % N;
      if (pending[c]) begin
        grant_hit = 1'b1;
        grant_idx = IDX_W'(c);
      end
    end
  end

  // Input history runs regardless of channel mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h0 <= '0;
      h1 <= '0;
    end else begin
      h0 <= in;
      h1 <= h0;
    end
  end

  // Mode registers, written through the config port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) mode[i] <= MODE_OFF;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (cfg_hit[i]) mode[i] <= cfg_mode;
      end
    end
  end

  // Pending and sticky overflow flags; a config write to a channel overrides everything on it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      overflow <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (cfg_hit[i]) begin
          pending[i]  <= 1'b0;
          overflow[i] <= 1'b0;
        end else begin
          if (detect[i]) begin
            pending[i] <= 1'b1;
          end else if (grant_sel[i]) begin
            pending[i] <= 1'b0;
          end
          if (detect[i] && pending[i] && !grant_sel[i]) begin
            overflow[i] <= 1'b1;
          end else if (ovf_clr) begin
            overflow[i] <= 1'b0;
          end
        end
      end
    end
  end

  // Output register and round-robin pointer; held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_idx   <= '0;
      evt_kind  <= MODE_OFF;
      ptr       <= IDX_W'(N - 1);
    end else if (load) begin
      evt_valid <= grant_hit;
      if (grant_hit) begin
        evt_idx  <= grant_idx;
        evt_kind <= mode[grant_idx];
        ptr      <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter: directed stimulus with a queue-based scoreboard for
// transferred events plus direct checks on timing, holding and flags.
module tb_edge_event_arbiter;

  localparam int N     = 4;
  localparam int IDX_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     in;
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_idx;
  logic [1:0]       cfg_mode;
  logic             ovf_clr;
  logic             evt_valid;
  logic             evt_ready;
  logic [IDX_W-1:0] evt_idx;
  logic [1:0]       evt_kind;
  logic [N-1:0]     overflow;

  int assert_count = 0;
  int fail_count   = 0;

  logic [IDX_W+1:0] exp_q[$];
  logic [IDX_W+1:0] sb_exp;

  edge_event_arbiter #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_mode  (cfg_mode),
    .ovf_clr   (ovf_clr),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_idx   (evt_idx),
    .evt_kind  (evt_kind),
    .overflow  (overflow)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Scoreboard monitor: every transfer must match the oldest expected event.
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      assert_count++;
      if (exp_q.size() == 0) begin
        fail_count++;
        $display("[TB] FAIL unexpected_event: got idx=%0d kind=%b, required no event", evt_idx, evt_kind);
      end else begin
        sb_exp = exp_q.pop_front();
        if ({evt_idx, evt_kind} !== sb_exp) begin
          fail_count++;
          $display("[TB] FAIL event_order: got idx=%0d kind=%b, required idx=%0d kind=%b",
                   evt_idx, evt_kind, sb_exp[IDX_W+1:2], sb_exp[1:0]);
        end
      end
    end
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int idx, input logic [1:0] kind);
    exp_q.push_back({IDX_W'(idx), kind});
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  task automatic cfg_write(input int idx, input logic [1:0] m);
    cfg_we   = 1'b1;
    cfg_idx  = IDX_W'(idx);
    cfg_mode = m;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in    = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Wait a bounded number of cycles for the scoreboard to empty.
  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check_output(name, exp_q.size(), 0);
  endtask

  task automatic apply_stimulus();
    // Reset values, before any clock edge
    #2;
    check_output("reset_valid", evt_valid, 0);
    check_output("reset_idx", evt_idx, 0);
    check_output("reset_kind", evt_kind, 0);
    check_output("reset_ovf", overflow, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Rise on channel 0: valid exactly in c+2 for one cycle
    cfg_write(0, 2'b01);
    tick();
    in[0] = 1'b1;
    push_exp(0, 2'b01);
    tick();
    check_output("rise_c1_valid", evt_valid, 0);
    tick();
    check_output("rise_c2_valid", evt_valid, 1);
    check_output("rise_c2_idx", evt_idx, 0);
    check_output("rise_c2_kind", evt_kind, 2'b01);
    tick();
    check_output("rise_c3_valid", evt_valid, 0);
    for (int k = 0; k < 5; k++) tick();
    check_output("rise_hold_valid", evt_valid, 0);
    drain("rise_drain");

    // Pulse on channel 1: 010 detects, 0110 does not
    cfg_write(1, 2'b11);
    tick();
    tick();
    in[1] = 1'b1;
    tick();
    in[1] = 1'b0;
    push_exp(1, 2'b11);
    tick();
    tick();
    check_output("pulse_c2_idx", evt_idx, 1);
    check_output("pulse_c2_kind", evt_kind, 2'b11);
    tick();
    in[1] = 1'b1;
    tick();
    tick();
    in[1] = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check_output("pulse_0110_valid", evt_valid, 0);
    drain("pulse_drain");

    // Round robin from a fresh pointer
    do_reset();
    for (int i = 0; i < N; i++) cfg_write(i, 2'b01);
    tick();
    in = 4'b1111;
    for (int i = 0; i < N; i++) push_exp(i, 2'b01);
    tick();
    tick();
    for (int i = 0; i < N; i++) begin
      check_output($sformatf("rr_all_valid%0d", i), evt_valid, 1);
      check_output($sformatf("rr_all_idx%0d", i), evt_idx, i);
      tick();
    end
    check_output("rr_all_done", evt_valid, 0);
    in = 4'b0000;
    tick();
    tick();
    in = 4'b1010;
    push_exp(1, 2'b01);
    push_exp(3, 2'b01);
    tick();
    tick();
    check_output("rr_pair_first", evt_idx, 1);
    tick();
    check_output("rr_pair_second", evt_idx, 3);
    tick();
    check_output("rr_pair_done", evt_valid, 0);
    drain("rr_drain");

    // Backpressure and overflow on channel 2 (fall mode)
    do_reset();
    evt_ready = 1'b0;
    cfg_write(2, 2'b10);
    in[2] = 1'b1;
    tick();
    tick();
    in[2] = 1'b0;
    push_exp(2, 2'b10);
    tick();
    tick();
    for (int k = 0; k < 10; k++) begin
      check_output($sformatf("bp_hold_valid%0d", k), evt_valid, 1);
      check_output($sformatf("bp_hold_idx%0d", k), evt_idx, 2);
      tick();
    end
    check_output("bp_hold_kind", evt_kind, 2'b10);
    in[2] = 1'b1;
    tick();
    in[2] = 1'b0;
    push_exp(2, 2'b10);
    tick();
    check_output("bp_no_ovf_yet", overflow, 4'b0000);
    in[2] = 1'b1;
    tick();
    in[2] = 1'b0;
    tick();
    tick();
    check_output("bp_overflow", overflow, 4'b0100);
    evt_ready = 1'b1;
    tick();
    check_output("bp_second_valid", evt_valid, 1);
    tick();
    check_output("bp_drained_valid", evt_valid, 0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check_output("bp_ovf_clr", overflow, 4'b0000);
    drain("bp_drain");

    // Config write in the same cycle as a detection wins
    cfg_write(0, 2'b01);
    tick();
    in[0]    = 1'b1;
    cfg_we   = 1'b1;
    cfg_idx  = 2'd0;
    cfg_mode = 2'b01;
    tick();
    cfg_we = 1'b0;
    tick();
    tick();
    check_output("cfgpri_no_event", evt_valid, 0);
    check_output("cfgpri_no_ovf", overflow[0], 0);
    in[0] = 1'b0;
    tick();
    in[0] = 1'b1;
    push_exp(0, 2'b01);
    tick();
    tick();
    check_output("cfgpri_next_valid", evt_valid, 1);
    check_output("cfgpri_next_idx", evt_idx, 0);
    tick();
    drain("cfgpri_drain");

    // Asynchronous reset while an event is held and overflow is 0101
    in = 4'b0000;
    cfg_write(2, 2'b01);
    evt_ready = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      in = 4'b0101;
      tick();
      in = 4'b0000;
      tick();
    end
    tick();
    check_output("pre_reset_valid", evt_valid, 1);
    check_output("pre_reset_ovf", overflow, 4'b0101);
    rst_n = 1'b0;
    #1;
    check_output("async_reset_valid", evt_valid, 0);
    check_output("async_reset_idx", evt_idx, 0);
    check_output("async_reset_kind", evt_kind, 0);
    check_output("async_reset_ovf", overflow, 4'b0000);
    tick();
    tick();
    rst_n     = 1'b1;
    evt_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in = (k % 2 == 0) ? 4'b1111 : 4'b0000;
      tick();
      check_output($sformatf("post_reset_quiet%0d", k), evt_valid, 0);
    end
    drain("final_drain");
  endtask

  initial begin
    rst_n     = 1'b0;
    in        = '0;
    cfg_we    = 1'b0;
    cfg_idx   = '0;
    cfg_mode  = 2'b00;
    ovf_clr   = 1'b0;
    evt_ready = 1'b1;
    apply_stimulus();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
